// File: rtl/accumulator_controller.sv
// rtl/accumulator_controller.sv - Moore control FSM for the 8-bit accumulator datapath.
// Optional HALT opcode (101) is enabled by defining CTRL_HALT_EN.
module accumulator_controller #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_NOT = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] toCU,
  output logic       pcEn,
  output logic       selAddress,
  output logic       mr,
  output logic       mw,
  output logic       LSEn,
  output logic       RSEn,
  output logic       DIEn,
  output logic       wordRegEn,
  output logic       dataRegEn,
  output logic       resultRegEn,
  output logic       selALUsrc,
  output logic       enb,
  output logic       CEn,
  output logic       ZEn,
  output logic       NEn,
  output logic [1:0] selData,
  output logic [1:0] selAddressAC,
  output logic [2:0] operation,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_F1, S_F2, S_MRD, S_EX, S_WBA, S_WBL, S_SRD, S_SWR,
    S_MV1, S_MV2, S_U1, S_U2
`ifdef CTRL_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       sel_address;
    logic       mr;
    logic       mw;
    logic       ls_en;
    logic       rs_en;
    logic       di_en;
    logic       word_reg_en;
    logic       data_reg_en;
    logic       result_reg_en;
    logic       sel_alu_src;
    logic       enb;
    logic       c_en;
    logic       z_en;
    logic       n_en;
    logic [1:0] sel_data;
    logic [1:0] sel_address_ac;
    logic [2:0] operation;
  } ctrl_t;

  state_t      r_state;
  logic [2:0]  r_op;
  ctrl_t       r_ctrl;
  logic        r_halted;
  logic [2:0]  w_op;
  state_t      w_next;
  ctrl_t       w_ctrl;

  function automatic state_t next_of(input state_t s, input logic [2:0] op);
    state_t n;
    n = S_F1;
    case (s)
      S_F1: begin
        if (op <= 3'b100)      n = S_F2;
        else if (op == 3'b110) n = S_MV1;
`ifdef CTRL_HALT_EN
        else if (op == 3'b101) n = S_HALT;
`endif
        else                   n = S_U1;
      end
      S_F2:  n = (op == 3'b001) ? S_SRD : S_MRD;
      S_MRD: n = (op == 3'b000) ? S_WBL : S_EX;
      S_EX:  n = S_WBA;
      S_SRD: n = S_SWR;
      S_MV1: n = S_MV2;
      S_U1:  n = S_U2;
`ifdef CTRL_HALT_EN
      S_HALT: n = S_HALT;
`endif
      default: n = S_F1;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_F1: begin
        c.mr = 1'b1; c.ls_en = 1'b1; c.pc_en = 1'b1;
      end
      S_F2: begin
        c.mr = 1'b1; c.rs_en = 1'b1; c.pc_en = 1'b1; c.di_en = 1'b1;
      end
      S_MRD: begin
        c.sel_address = 1'b1; c.mr = 1'b1; c.word_reg_en = 1'b1;
      end
      S_EX: begin
        c.sel_alu_src = 1'b1; c.result_reg_en = 1'b1;
        c.z_en = 1'b1; c.n_en = 1'b1;
        c.c_en = (op != 3'b100);
        case (op)
          3'b011:  c.operation = ALU_SUB;
          3'b100:  c.operation = ALU_AND;
          default: c.operation = ALU_ADD;
        endcase
      end
      S_WBA: begin
        c.sel_data = 2'd1; c.enb = 1'b1;
      end
      S_WBL: c.enb = 1'b1;
      S_SRD: c.data_reg_en = 1'b1;
      S_SWR: begin
        c.sel_address = 1'b1; c.mw = 1'b1;
      end
      S_MV1: begin
        c.sel_address_ac = 2'd1; c.data_reg_en = 1'b1;
      end
      S_MV2: begin
        c.sel_address_ac = 2'd2; c.sel_data = 2'd2; c.enb = 1'b1;
      end
      S_U1: begin
        c.sel_address_ac = 2'd1; c.result_reg_en = 1'b1;
        c.z_en = 1'b1; c.n_en = 1'b1;
        c.c_en = (op != 3'b111);
        c.operation = (op == 3'b111) ? ALU_NOT : ALU_ADD;
      end
      S_U2: begin
        c.sel_address_ac = 2'd2; c.sel_data = 2'd1; c.enb = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // The opcode is only on the bus during F1; later states use the latched copy.
  always_comb begin
    w_op   = (r_state == S_F1) ? toCU : r_op;
    w_next = next_of(r_state, w_op);
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_F1;
      r_op     <= 3'b000;
      r_ctrl   <= decode(S_F1, 3'b000);
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_F1) r_op <= toCU;
      r_ctrl  <= decode(w_next, w_op);
`ifdef CTRL_HALT_EN
      r_halted <= (w_next == S_HALT);
`else
      r_halted <= 1'b0;
`endif
    end
  end

  // Reset blanks every output immediately, even mid-instruction.
  assign w_ctrl       = reset ? '0 : r_ctrl;
  assign pcEn         = w_ctrl.pc_en;
  assign selAddress   = w_ctrl.sel_address;
  assign mr           = w_ctrl.mr;
  assign mw           = w_ctrl.mw;
  assign LSEn         = w_ctrl.ls_en;
  assign RSEn         = w_ctrl.rs_en;
  assign DIEn         = w_ctrl.di_en;
  assign wordRegEn    = w_ctrl.word_reg_en;
  assign dataRegEn    = w_ctrl.data_reg_en;
  assign resultRegEn  = w_ctrl.result_reg_en;
  assign selALUsrc    = w_ctrl.sel_alu_src;
  assign enb          = w_ctrl.enb;
  assign CEn          = w_ctrl.c_en;
  assign ZEn          = w_ctrl.z_en;
  assign NEn          = w_ctrl.n_en;
  assign selData      = w_ctrl.sel_data;
  assign selAddressAC = w_ctrl.sel_address_ac;
  assign operation    = w_ctrl.operation;
  assign halted       = reset ? 1'b0 : r_halted;

endmodule

// File: tb/tb_accumulator_controller.sv
// tb/tb_accumulator_controller.sv - directed checks of accumulator_controller state outputs.
module tb_accumulator_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] toCU = 3'b000;
  logic       pcEn, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn, dataRegEn;
  logic       resultRegEn, selALUsrc, enb, CEn, ZEn, NEn, halted;
  logic [1:0] selData, selAddressAC;
  logic [2:0] operation;
  logic [22:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator_controller dut (
    .clk(clk), .reset(reset), .toCU(toCU),
    .pcEn(pcEn), .selAddress(selAddress), .mr(mr), .mw(mw),
    .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn), .wordRegEn(wordRegEn),
    .dataRegEn(dataRegEn), .resultRegEn(resultRegEn), .selALUsrc(selALUsrc),
    .enb(enb), .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .selData(selData),
    .selAddressAC(selAddressAC), .operation(operation), .halted(halted)
  );

  assign obs = {pcEn, selAddress, mr, mw, LSEn, RSEn, DIEn, wordRegEn, dataRegEn,
                resultRegEn, selALUsrc, enb, CEn, ZEn, NEn, selData, selAddressAC,
                operation, halted};

  function automatic logic [22:0] mk(input bit pc, sa, rd, wr_m, ls, rs, di, wr, dr, rr,
                                     alu, en, c, z, n, input logic [1:0] sd, sac,
                                     input logic [2:0] op, input bit h);
    return {pc, sa, rd, wr_m, ls, rs, di, wr, dr, rr, alu, en, c, z, n, sd, sac, op, h};
  endfunction

  localparam logic [22:0] E_ZERO   = '0;
  localparam logic [22:0] E_F1     = mk(1,0,1,0,1,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_F2     = mk(1,0,1,0,0,1,1,0,0,0,0,0,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_MRD    = mk(0,1,1,0,0,0,0,1,0,0,0,0,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_EX_ADD = mk(0,0,0,0,0,0,0,0,0,1,1,0,1,1,1,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_EX_SUB = mk(0,0,0,0,0,0,0,0,0,1,1,0,1,1,1,2'd0,2'd0,3'b001,0);
  localparam logic [22:0] E_EX_AND = mk(0,0,0,0,0,0,0,0,0,1,1,0,0,1,1,2'd0,2'd0,3'b010,0);
  localparam logic [22:0] E_WBA    = mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,2'd1,2'd0,3'b000,0);
  localparam logic [22:0] E_WBL    = mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_SRD    = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_SWR    = mk(0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0,3'b000,0);
  localparam logic [22:0] E_MV1    = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,2'd0,2'd1,3'b000,0);
  localparam logic [22:0] E_MV2    = mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,2'd2,2'd2,3'b000,0);
  localparam logic [22:0] E_U1_SHL = mk(0,0,0,0,0,0,0,0,0,1,0,0,1,1,1,2'd0,2'd1,3'b000,0);
  localparam logic [22:0] E_U1_NOT = mk(0,0,0,0,0,0,0,0,0,1,0,0,0,1,1,2'd0,2'd1,3'b011,0);
  localparam logic [22:0] E_U2     = mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,2'd1,2'd2,3'b000,0);
  localparam logic [22:0] E_HALT   = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,2'd0,2'd0,3'b000,1);

  task automatic test_reset();
    reset = 1'b1;
    toCU  = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs !== E_ZERO) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, E_ZERO);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", obs, E_F1);
    end
  endtask

  task automatic test_lda();
    logic [22:0] e [4] = '{E_F1, E_F2, E_MRD, E_WBL};
    toCU = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL lda cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      @(negedge clk);
      toCU = 3'b110;
    end
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL lda_return: got %h expected %h", obs, E_F1);
    end
  endtask

  task automatic test_alu(input logic [2:0] op, input logic [22:0] ex, input string name);
    logic [22:0] e [5];
    e = '{E_F1, E_F2, E_MRD, ex, E_WBA};
    toCU = op;
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, e[i]);
      end
      @(negedge clk);
      toCU = 3'b000;
    end
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL %s_return: got %h expected %h", name, obs, E_F1);
    end
  endtask

  task automatic test_sta();
    logic [22:0] e [4] = '{E_F1, E_F2, E_SRD, E_SWR};
    toCU = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL sta cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      @(negedge clk);
      toCU = 3'b000;
    end
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL sta_return: got %h expected %h", obs, E_F1);
    end
  endtask

  task automatic test_one_byte(input logic [2:0] op, input logic [22:0] e1,
                               input logic [22:0] e2, input string name);
    logic [22:0] e [3];
    e = '{E_F1, e1, e2};
    toCU = op;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, e[i]);
      end
      @(negedge clk);
      toCU = 3'b010;
    end
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL %s_return: got %h expected %h", name, obs, E_F1);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] e [4] = '{E_F1, E_F2, E_MRD, E_EX_ADD};
    toCU = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (obs !== e[i]) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      if (i < 3) begin
        @(negedge clk);
        toCU = 3'b000;
      end
    end
    reset = 1'b1;
    #1; checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL reset_mid_forced: got %h expected %h", obs, E_ZERO);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== E_ZERO || enb !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_wb: got %h expected %h", obs, E_ZERO);
    end
    reset = 1'b0;
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL reset_mid_f1: got %h expected %h", obs, E_F1);
    end
  endtask

`ifdef CTRL_HALT_EN
  task automatic test_halt();
    toCU = 3'b101;
    @(negedge clk);
    toCU = 3'b000;
    for (int i = 0; i < 12; i++) begin
      #1; checks++;
      if (obs !== E_HALT) begin
        failures++;
        $display("FAIL halt cycle %0d: got %h expected %h", i, obs, E_HALT);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1; checks++;
    if (obs !== E_F1) begin
      failures++;
      $display("FAIL halt_exit: got %h expected %h", obs, E_F1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lda();
    test_alu(3'b011, E_EX_SUB, "sub");
    test_alu(3'b010, E_EX_ADD, "add");
    test_alu(3'b100, E_EX_AND, "and");
    test_sta();
    test_one_byte(3'b110, E_MV1, E_MV2, "mov");
    test_one_byte(3'b111, E_U1_NOT, E_U2, "not");
    test_lda();
    test_reset_mid();
`ifdef CTRL_HALT_EN
    test_halt();
`else
    test_one_byte(3'b101, E_U1_SHL, E_U2, "shl");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_controller.md
Name: accumulator_controller

Overview:
- Multi-cycle control unit for the 8-bit accumulator datapath (4 accumulators, 13-bit address space, C/Z/N flags).
- Consumes the 3-bit opcode driven from memory output bits [7:5].
- Produces every datapath enable and select as a Moore function of an internal FSM state.
- Sequences fetch, decode, execute and write-back for one- and two-byte instructions.

Parameters:
ALU_ADD, 3'b000, ALU func code for A+B
ALU_SUB, 3'b001, ALU func code for A-B
ALU_AND, 3'b010, ALU func code for A&B
ALU_NOT, 3'b011, ALU func code for ~A

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
toCU  input  3  opcode = current memory output [7:5]
pcEn, selAddress, mr, mw  output  1 each  PC increment, address select (0 = PC, 1 = {LS[4:0],RS}), memory read, memory write
LSEn, RSEn, DIEn, wordRegEn, dataRegEn, resultRegEn  output  1 each  datapath register enables
selALUsrc, enb, CEn, ZEn, NEn  output  1 each  ALU B select (0 = AC, 1 = word reg), accumulator write, flag enables
selData  output  2  AC write data: 0 = word reg, 1 = result reg, 2 = data reg
selAddressAC  output  2  AC index: 0 = DI[4:3], 1 = LS[1:0], 2 = LS[3:2]
operation  output  3  ALU function
halted  output  1  high in HALT state (tied 0 without macro)

Behaviour:
- Memory read is combinational; memory write commits at the clock edge. Outputs are decoded from state only.
- Reset: state <- F1, latched opcode <- 0. All outputs are forced to 0 while reset is high, including mid-instruction; no partial write-back occurs.
- Outputs not listed for a state are 0.
- Opcode set:
  - Two-byte: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND.
  - One-byte: 101 SHL, 110 MOV, 111 NOT.
- F1: selAddress=0, mr, LSEn, pcEn; latch toCU into op. Next: F2 if op <= 100, MV1 if 110, U1 if 101/111.
- F2: selAddress=0, mr, RSEn, pcEn, DIEn. Next: SRD if STA, else MRD.
- MRD: selAddress=1, mr, wordRegEn. Next: WBL if LDA, else EX.
- EX: selAddressAC=0, selALUsrc=1, resultRegEn, ZEn, NEn.
  - operation = ADD/SUB/AND per op.
  - CEn=1 for ADD/SUB, CEn=0 for AND.
  - Next: WBA.
- WBA: selAddressAC=0, selData=1, enb. Next: F1.
- WBL: selAddressAC=0, selData=0, enb. Next: F1.
- SRD: selAddressAC=0, dataRegEn. Next: SWR.
- SWR: selAddress=1, mw. Next: F1.
- MV1: selAddressAC=1, dataRegEn. Next: MV2.
- MV2: selAddressAC=2, selData=2, enb. Next: F1.
- U1: selAddressAC=1, selALUsrc=0, resultRegEn, ZEn, NEn, CEn.
  - operation = ADD for SHL (A+A), NOT for 111.
  - For NOT, CEn=0.
  - Next: U2.
- U2: selAddressAC=2, selData=1, enb. Next: F1.
- Latency in cycles: LDA 4, STA 4, ADD/SUB/AND 5, MOV/SHL/NOT 3.
- Exactly one pcEn per fetched byte.
- PC wrap at 13 bits is the datapath's concern; the controller is unaffected.
- mr and mw are never high in the same cycle.
- enb is never high in a state where selAddressAC is undefined.
- Unknown or X opcode is not possible (3-bit code fully decoded).

Optional Feature:
CTRL_HALT_EN
- Defined: opcode 101 means HALT. F1 -> HALT.
  - In HALT, all outputs are 0 and halted=1.
  - HALT is left only via reset.
- Undefined: 101 means SHL as above; halted is tied 0; no HALT state exists.

Test Plan:
- Reset for 2 cycles, release: F1 outputs (mr=1, LSEn=1, pcEn=1, selAddress=0) appear on the first cycle after release; all outputs are 0 during reset.
- toCU=000 (LDA) at F1: the 4-cycle sequence F1,F2,MRD,WBL has enb=1, selData=0, selAddressAC=0 only in cycle 4, and pcEn=1 in cycles 1-2.
- toCU=011 (SUB): in cycle 4, operation=001, CEn=ZEn=NEn=1, selALUsrc=1; in cycle 5, enb=1, selData=1; back to F1 on cycle 6.
- toCU=001 (STA): cycle 3 dataRegEn=1, cycle 4 mw=1 with selAddress=1; enb never asserted.
- toCU=110 then 111: MOV shows dataRegEn (selAddressAC=1) then enb (selAddressAC=2, selData=2). NOT shows operation=011 and CEn=0.
- Reset asserted during EX of ADD: next cycle state=F1, no enb pulse. With CTRL_HALT_EN, toCU=101 leads to halted=1 held for 10+ cycles until reset.
